// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Latency: n/a (declarations only). Backpressure: n/a.
// Holds the FSM encoding, the fetch-entry layout and the default reset PC.
package inst_fetch_queue_pkg;

   typedef enum logic [1:0] {
      FETCH_IDLE  = 2'd0,
      FETCH_RUN   = 2'd1,
      FETCH_DRAIN = 2'd2
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INST         = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order DEPTH-entry register FIFO holding {pc, inst} fetch entries.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: caller must not push when full or pop when empty; flush clears everything.
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_dat_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [WIDTH-1:0]         head_dat_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop_i) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   assign full_o     = (count_q == CW'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign head_dat_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch_queue.sv
// RV32I fetch front end: PC generation, up to DEPTH outstanding imem requests, in-order queue to decode.
// Latency: grant at t, rvalid at t+1, out_valid at t+2. Optional FETCH_STATS_EN adds fetch_bubble_cnt.
// Backpressure: requests stop once queued + outstanding reaches DEPTH; head held stable while !out_ready.
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0] fetch_bubble_cnt
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   rsp_pc_q, rsp_pc_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] drop_q, drop_d;

   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   fetch_entry_t  push_entry, head_entry;
   logic          room;

   assign room = ({1'b0, fifo_count} + {1'b0, outst_q}) < (CW+1)'(DEPTH);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      rsp_pc_d   = rsp_pc_q;
      outst_d    = outst_q;
      drop_d     = drop_q;
      imem_req   = 1'b0;
      fifo_push  = 1'b0;
      push_entry = '{pc: rsp_pc_q, inst: imem_rdata};

      unique case (state_q)
         FETCH_IDLE: state_d = FETCH_RUN;
         FETCH_RUN: begin
            imem_req = room;
            if (imem_req && imem_gnt) begin
               pc_d    = pc_q + 32'd4;
               outst_d = outst_d + CW'(1);
            end
            // rsp_pc_q tracks the PC of the oldest live request, i.e. the tag of the next response.
            if (imem_rvalid) begin
               fifo_push = 1'b1;
               outst_d   = outst_d - CW'(1);
               rsp_pc_d  = rsp_pc_q + 32'd4;
            end
         end
         FETCH_DRAIN: begin
            if (imem_rvalid) drop_d = drop_q - CW'(1);
            if (drop_d == '0) state_d = FETCH_RUN;
         end
         default: state_d = FETCH_IDLE;
      endcase

      // Only one of outst_q/drop_q is non-zero at a time, so their sum is everything in flight.
      if (redirect) begin
         imem_req  = 1'b0;
         fifo_push = 1'b0;
         pc_d      = word_align(redirect_pc);
         rsp_pc_d  = word_align(redirect_pc);
         outst_d   = '0;
         drop_d    = outst_q + drop_q - CW'(imem_rvalid);
         state_d   = (drop_d != '0) ? FETCH_DRAIN : FETCH_RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= FETCH_IDLE;
         pc_q     <= RESET_PC;
         rsp_pc_q <= RESET_PC;
         outst_q  <= '0;
         drop_q   <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         rsp_pc_q <= rsp_pc_d;
         outst_q  <= outst_d;
         drop_q   <= drop_d;
      end
   end

   assign imem_addr = pc_q;
   assign out_valid = !fifo_empty;
   assign fifo_pop  = out_valid && out_ready;
   assign out_pc    = head_entry.pc;
   assign out_inst  = head_entry.inst;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (64)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (fifo_push),
      .push_dat_i (push_entry),
      .pop_i      (fifo_pop),
      .flush_i    (redirect),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count),
      .head_dat_o (head_entry)
   );

   a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(fifo_push && fifo_full));

`ifdef FETCH_STATS_EN
   logic [31:0] bubble_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_q <= '0;
      end else if (out_ready && !out_valid && state_q != FETCH_IDLE && bubble_q != 32'hFFFF_FFFF) begin
         bubble_q <= bubble_q + 32'd1;
      end
   end

   assign fetch_bubble_cnt = bubble_q;
`endif

endmodule
